// File: rtl/uart_int1_fabric_reset_ctrl.sv
// Fabric reset controller for the UART_INT1 fabric: waits for a stable FCCC lock, then releases FAB_RESET_N.
// Optional build macro FAB_RESET_LOCK_FILTER_EN adds a lock-low glitch filter in RUN.
module uart_int1_fabric_reset_ctrl #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int SYNC_STAGES        = 2,
    parameter int LOSS_CNT_W         = 8,
    parameter int LOCK_FILTER_CYCLES = 4
) (
    input  logic                  GL0,
    input  logic                  POWER_ON_RESET_N,
    input  logic                  LOCK,
    input  logic                  EXT_RESET_N,
    input  logic                  SW_RESET_REQ,
    input  logic                  CLR_STATUS,
    output logic                  FAB_RESET_N,
    output logic                  READY,
    output logic                  LOCK_LOST,
    output logic [LOSS_CNT_W-1:0] LOCK_LOSS_CNT,
    output logic [2:0]            STATE
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_e;

    localparam int MAX_CNT = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT);
    localparam logic [CNT_W-1:0]      STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [LOSS_CNT_W-1:0] LOSS_MAX    = {LOSS_CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic [SYNC_STAGES-1:0] ext_sync_q;
    logic                   lock_s;
    logic                   ext_s;
    logic                   loss_s;
    logic                   loss_evt_s;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   fab_q;
    logic                   ready_q;
    logic                   lost_q, lost_d;
    logic [LOSS_CNT_W-1:0]  lcnt_q, lcnt_d;
    logic [LOSS_CNT_W-1:0]  lcnt_base_s;

    // Two-flop style synchronisers for the asynchronous LOCK and EXT_RESET_N inputs
    always_ff @(posedge GL0 or negedge POWER_ON_RESET_N) begin
        if (!POWER_ON_RESET_N) begin
            lock_sync_q <= '0;
            ext_sync_q  <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], LOCK};
            ext_sync_q  <= {ext_sync_q[SYNC_STAGES-2:0], EXT_RESET_N};
        end
    end

    assign lock_s = lock_sync_q[SYNC_STAGES-1];
    assign ext_s  = ext_sync_q[SYNC_STAGES-1];

`ifdef FAB_RESET_LOCK_FILTER_EN
    localparam int FILT_W = $clog2(LOCK_FILTER_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER_CYCLES - 1);

    logic [FILT_W-1:0] filt_q, filt_d;

    // Loss is declared only on the last of LOCK_FILTER_CYCLES consecutive low cycles in RUN
    assign loss_s = (state_q == ST_RUN) && !lock_s && (filt_q == FILT_LAST);

    // Consecutive lock-low counter; restarts on lock high or when RUN is left
    always_comb begin
        filt_d = '0;
        if ((state_d == ST_RUN) && !lock_s) begin
            filt_d = filt_q + FILT_W'(1);
        end else begin
            filt_d = '0;
        end
    end

    // Filter counter register
    always_ff @(posedge GL0 or negedge POWER_ON_RESET_N) begin
        if (!POWER_ON_RESET_N) begin
            filt_q <= '0;
        end else begin
            filt_q <= filt_d;
        end
    end
`else
    assign loss_s = (state_q == ST_RUN) && !lock_s;
`endif

    assign loss_evt_s = loss_s && ext_s;

    // Next-state logic: external reset dominates, then lock loss, then software request
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!ext_s) begin
            state_d = ST_RESET;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
                ST_WAIT_LOCK: begin
                    cnt_d = '0;
                    if (lock_s) begin
                        state_d = ST_STABLE;
                    end else begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    cnt_d = '0;
                    if (loss_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (SW_RESET_REQ) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Sticky status: a clear and a loss in the same cycle leave the loss recorded
    always_comb begin
        lost_d      = lost_q;
        lcnt_base_s = lcnt_q;
        if (CLR_STATUS) begin
            lost_d      = 1'b0;
            lcnt_base_s = '0;
        end else begin
            lcnt_base_s = lcnt_q;
        end
        if (loss_evt_s) begin
            lost_d = 1'b1;
            lcnt_d = (lcnt_base_s == LOSS_MAX) ? lcnt_base_s : lcnt_base_s + LOSS_CNT_W'(1);
        end else begin
            lcnt_d = lcnt_base_s;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge GL0 or negedge POWER_ON_RESET_N) begin
        if (!POWER_ON_RESET_N) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            fab_q   <= 1'b0;
            ready_q <= 1'b0;
            lost_q  <= 1'b0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fab_q   <= (state_d == ST_RUN);
            ready_q <= (state_d == ST_RUN);
            lost_q  <= lost_d;
            lcnt_q  <= lcnt_d;
        end
    end

    assign FAB_RESET_N   = fab_q;
    assign READY         = ready_q;
    assign LOCK_LOST     = lost_q;
    assign LOCK_LOSS_CNT = lcnt_q;
    assign STATE         = state_q;

endmodule
